// File: rtl/ex_stage.sv
// ex_stage: execute stage behind the ID/EX register. It forwards operands, runs
// the ALU and holds the result in the EX/MEM register. When EX_MUL_EN is defined,
// an iterative radix-2 shift-add multiplier is added. It stalls IF/ID and ID/EX
// while a multiply is in flight.
module ex_stage #(
  parameter int XLEN       = 64,
  parameter int MUL_CYCLES = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush_in,
  input  logic            valid_in,
  input  logic            alu_src_in,
  input  logic            mem_to_reg_in,
  input  logic            reg_write_in,
  input  logic            mem_read_in,
  input  logic            mem_write_in,
  input  logic [3:0]      alu_op_in,
  input  logic [XLEN-1:0] rs1_data_in,
  input  logic [XLEN-1:0] rs2_data_in,
  input  logic [4:0]      rs1_in,
  input  logic [4:0]      rs2_in,
  input  logic [4:0]      rd_in,
  input  logic [XLEN-1:0] imm_in,
  input  logic            memwb_reg_write_in,
  input  logic [4:0]      memwb_rd_in,
  input  logic [XLEN-1:0] memwb_data_in,
  output logic            stall_out,
  output logic            ex_valid_out,
  output logic [XLEN-1:0] ex_result_out,
  output logic [XLEN-1:0] ex_store_data_out,
  output logic [4:0]      ex_rd_out,
  output logic            ex_reg_write_out,
  output logic            ex_mem_to_reg_out,
  output logic            ex_mem_read_out,
  output logic            ex_mem_write_out,
  output logic            ex_zero_out
);

  localparam int SHW = $clog2(XLEN);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_SLL  = 4'd5;
  localparam logic [3:0] OP_SRL  = 4'd6;
  localparam logic [3:0] OP_SRA  = 4'd7;
  localparam logic [3:0] OP_SLT  = 4'd8;
  localparam logic [3:0] OP_SLTU = 4'd9;
  localparam logic [3:0] OP_MUL  = 4'd10;

  if (MUL_CYCLES != XLEN) begin : g_cfg_err
    $error("ex_stage: MUL_CYCLES must equal XLEN");
  end

  typedef struct packed {
    logic            valid;
    logic            reg_write;
    logic            mem_to_reg;
    logic            mem_read;
    logic            mem_write;
    logic [4:0]      rd;
    logic [XLEN-1:0] result;
    logic [XLEN-1:0] store_data;
  } exmem_t;

  exmem_t          exmem_q, exmem_d;
  logic            zero_q;
  logic [XLEN-1:0] fwd_a, fwd_b, op_a, op_b, alu_y, mul_y;
  logic [SHW-1:0]  shamt;
  logic            exmem_fwd_ok;
  logic            issue_alu, mul_done, stall_c;

  // Loads leave EX/MEM holding an address, not the loaded data, so they never forward.
  assign exmem_fwd_ok = ex_valid_out & ex_reg_write_out & ~ex_mem_read_out;

  function automatic logic [XLEN-1:0] fwd(
    input logic [4:0] idx, input logic [XLEN-1:0] rf,
    input logic ex_ok, input logic [4:0] ex_rd, input logic [XLEN-1:0] ex_val,
    input logic wb_ok, input logic [4:0] wb_rd, input logic [XLEN-1:0] wb_val);
    logic [XLEN-1:0] v;
    v = rf;
    if (idx != 5'd0) begin
      if (ex_ok && ex_rd == idx)      v = ex_val;
      else if (wb_ok && wb_rd == idx) v = wb_val;
    end
    return v;
  endfunction

  // operand forwarding and selection
  always_comb begin
    fwd_a = fwd(rs1_in, rs1_data_in, exmem_fwd_ok, ex_rd_out, ex_result_out,
                memwb_reg_write_in, memwb_rd_in, memwb_data_in);
    fwd_b = fwd(rs2_in, rs2_data_in, exmem_fwd_ok, ex_rd_out, ex_result_out,
                memwb_reg_write_in, memwb_rd_in, memwb_data_in);
    op_a  = fwd_a;
    op_b  = alu_src_in ? imm_in : fwd_b;
    shamt = op_b[SHW-1:0];
  end

  // single-cycle ALU; MUL and the spare codes produce 0 here
  always_comb begin
    alu_y = '0;
    case (alu_op_in)
      OP_ADD:  alu_y = op_a + op_b;
      OP_SUB:  alu_y = op_a - op_b;
      OP_AND:  alu_y = op_a & op_b;
      OP_OR:   alu_y = op_a | op_b;
      OP_XOR:  alu_y = op_a ^ op_b;
      OP_SLL:  alu_y = op_a << shamt;
      OP_SRL:  alu_y = op_a >> shamt;
      OP_SRA:  alu_y = $signed(op_a) >>> shamt;
      OP_SLT:  alu_y = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      OP_SLTU: alu_y = {{(XLEN-1){1'b0}}, (op_a < op_b)};
      default: alu_y = '0;
    endcase
  end

`ifdef EX_MUL_EN
  localparam int CNT_W = $clog2(MUL_CYCLES);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t          state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [XLEN-1:0] mcand, mplier, acc;
  logic            mul_start, mul_last;

  assign mul_start = valid_in & (alu_op_in == OP_MUL) & ~flush_in;
  assign mul_last  = (cnt == CNT_W'(MUL_CYCLES - 1));
  assign mul_y     = acc + (mplier[0] ? mcand : '0);

  // FSM state register
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else      state <= state_nxt;

  // FSM next state: a flush aborts a multiply in flight
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (mul_start) state_nxt = BUSY;
      BUSY: if (flush_in || mul_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs: stall until the final step so ID/EX advances with the product
  always_comb begin
    stall_c   = 1'b0;
    mul_done  = 1'b0;
    issue_alu = 1'b0;
    case (state)
      IDLE: begin
        stall_c   = mul_start;
        issue_alu = valid_in & ~flush_in & (alu_op_in != OP_MUL);
      end
      BUSY: begin
        stall_c  = ~flush_in & ~mul_last;
        mul_done = ~flush_in & mul_last;
      end
      default: ;
    endcase
  end

  // shift-add datapath: operands latched at acceptance, one partial product per cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0; mcand <= '0; mplier <= '0; acc <= '0;
    end else if (state == IDLE) begin
      if (mul_start) begin
        cnt <= '0; mcand <= op_a; mplier <= op_b; acc <= '0;
      end
    end else if (flush_in) begin
      cnt <= '0; acc <= '0;
    end else begin
      acc    <= mul_y;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + 1'b1;
    end
  end
`else
  assign stall_c   = 1'b0;
  assign mul_done  = 1'b0;
  assign issue_alu = valid_in & ~flush_in;
  assign mul_y     = '0;
`endif

  // stall is forced low while reset is asserted
  assign stall_out = stall_c & rst;

  // next EX/MEM contents: ALU result, finished product, or a bubble
  always_comb begin
    exmem_d = '0;
    if (issue_alu || mul_done) begin
      exmem_d.valid      = 1'b1;
      exmem_d.reg_write  = reg_write_in;
      exmem_d.mem_to_reg = mem_to_reg_in;
      exmem_d.mem_read   = mem_read_in;
      exmem_d.mem_write  = mem_write_in;
      exmem_d.rd         = rd_in;
      exmem_d.result     = mul_done ? mul_y : alu_y;
      exmem_d.store_data = fwd_b;
    end
  end

  // EX/MEM register with registered zero flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      exmem_q <= '0;
      zero_q  <= 1'b0;
    end else begin
      exmem_q <= exmem_d;
      zero_q  <= exmem_d.valid & (exmem_d.result == '0);
    end
  end

  assign ex_valid_out      = exmem_q.valid;
  assign ex_reg_write_out  = exmem_q.reg_write;
  assign ex_mem_to_reg_out = exmem_q.mem_to_reg;
  assign ex_mem_read_out   = exmem_q.mem_read;
  assign ex_mem_write_out  = exmem_q.mem_write;
  assign ex_rd_out         = exmem_q.rd;
  assign ex_result_out     = exmem_q.result;
  assign ex_store_data_out = exmem_q.store_data;
  assign ex_zero_out       = zero_q;

endmodule
